// File: rtl/lcd_bus_receiver.sv
// lcd_bus_receiver
//   Passive HD44780-style receiver. Watches the character-LCD bus, decodes
//   each write strobe (falling edge of EN) into a command or a data write,
//   tracks the DDRAM address counter, entry direction and display-on bit,
//   and keeps a 32-entry shadow of the visible 16x2 screen. A busy model
//   rejects strobes that arrive before the previous operation has finished.
//
// Ports
//   iCLK, iRST_N      clock, asynchronous active-low reset
//   LCD_DATA[7:0]     LCD data bus (asynchronous to iCLK)
//   LCD_RS            0 = command, 1 = data
//   LCD_RW            0 = write, 1 = read (reads are rejected)
//   LCD_EN            enable strobe, bus latched on its falling edge
//   iRD_ADDR[4:0]     shadow index (0-15 line 1, 16-31 line 2)
//   oRD_CHAR[7:0]     registered shadow[iRD_ADDR]
//   oCURSOR_ADDR[6:0] DDRAM address counter
//   oDISP_ON          D bit of the last Display Control command
//   oBUSY             busy flag
//   oWR_STB           one-cycle pulse per accepted data write
//   oCMD_ERR          one-cycle pulse per rejected strobe
module lcd_bus_receiver #(
   parameter int CMD_BUSY_CYC = 2000,
   parameter int CLR_BUSY_CYC = 76000
) (
   input  logic       iCLK,
   input  logic       iRST_N,
   input  logic [7:0] LCD_DATA,
   input  logic       LCD_RS,
   input  logic       LCD_RW,
   input  logic       LCD_EN,
   input  logic [4:0] iRD_ADDR,
   output logic [7:0] oRD_CHAR,
   output logic [6:0] oCURSOR_ADDR,
   output logic       oDISP_ON,
   output logic       oBUSY,
   output logic       oWR_STB,
   output logic       oCMD_ERR
);

   localparam int MAXC = (CLR_BUSY_CYC > CMD_BUSY_CYC) ? CLR_BUSY_CYC : CMD_BUSY_CYC;
   localparam int CW   = $clog2(MAXC) + 1;

   typedef enum logic {ST_IDLE, ST_BUSY} state_t;

   // Bus bundle layout: {EN, RW, RS, DATA}
   logic [10:0]   r_sync1, r_sync2, r_edge;
   logic [7:0]    r_shadow [32];
   logic [6:0]    r_ac;
   logic          r_id, r_disp, r_wr_stb, r_cmd_err;
   logic [7:0]    r_rd_char;
   state_t        r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;

   logic       w_strobe, w_accept, w_reject, w_rs, w_rw;
   logic [7:0] w_data;
   logic [6:0] w_ac_nxt;
   logic       w_id_nxt, w_disp_nxt, w_clear, w_long, w_wr_en;
   logic [4:0] w_wr_idx;

   // Address counter step. The two visible lines are 0x00-0x27 and
   // 0x40-0x67; stepping off the end of one lands on the start of the other.
   // Values outside those ranges just move by one.
   function automatic logic [6:0] f_step(input logic [6:0] a, input logic up);
      if (up) begin
         if (a == 7'h27)      f_step = 7'h40;
         else if (a == 7'h67) f_step = 7'h00;
         else                 f_step = a + 7'd1;
      end else begin
         if (a == 7'h00)      f_step = 7'h67;
         else if (a == 7'h40) f_step = 7'h27;
         else                 f_step = a - 7'd1;
      end
   endfunction

   // DATA/RS/RW come from the edge register, i.e. the sample where EN was 1.
   assign w_strobe = r_edge[10] & ~r_sync2[10];
   assign w_rw     = r_edge[9];
   assign w_rs     = r_edge[8];
   assign w_data   = r_edge[7:0];
   assign w_accept = w_strobe & ~w_rw & (r_state == ST_IDLE);
   assign w_reject = w_strobe & ~w_accept;

   always_comb begin
      w_ac_nxt   = r_ac;
      w_id_nxt   = r_id;
      w_disp_nxt = r_disp;
      w_clear    = 1'b0;
      w_long     = 1'b0;
      w_wr_en    = 1'b0;
      // Line 1 is AC 0x00-0x0F, line 2 is AC 0x40-0x4F
      w_wr_idx   = {r_ac[6], r_ac[3:0]};
      if (w_rs) begin
         w_wr_en  = (r_ac[5:4] == 2'b00);
         w_ac_nxt = f_step(r_ac, r_id);
      end else begin
         casez (w_data)
            8'b1???????: w_ac_nxt = w_data[6:0];
            8'b01??????: ;
            8'b001?????: ;
            8'b0001????: if (!w_data[3]) w_ac_nxt = f_step(r_ac, w_data[2]);
            8'b00001???: w_disp_nxt = w_data[2];
            8'b000001??: w_id_nxt = w_data[1];
            8'b0000001?: begin
               w_ac_nxt = 7'h00;
               w_long   = 1'b1;
            end
            8'b00000001: begin
               w_ac_nxt = 7'h00;
               w_id_nxt = 1'b1;
               w_clear  = 1'b1;
               w_long   = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: if (w_accept) begin
            w_state_nxt = ST_BUSY;
            w_cnt_nxt   = w_long ? CW'(CLR_BUSY_CYC - 1) : CW'(CMD_BUSY_CYC - 1);
         end
         ST_BUSY: begin
            if (r_cnt == '0) w_state_nxt = ST_IDLE;
            else             w_cnt_nxt   = r_cnt - CW'(1);
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         r_sync1   <= '0;
         r_sync2   <= '0;
         r_edge    <= '0;
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_ac      <= '0;
         r_id      <= 1'b1;
         r_disp    <= 1'b0;
         r_wr_stb  <= 1'b0;
         r_cmd_err <= 1'b0;
         r_rd_char <= '0;
         for (int i = 0; i < 32; i++) r_shadow[i] <= 8'h20;
      end else begin
         r_sync1   <= {LCD_EN, LCD_RW, LCD_RS, LCD_DATA};
         r_sync2   <= r_sync1;
         r_edge    <= r_sync2;
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_wr_stb  <= w_accept & w_rs;
         r_cmd_err <= w_reject;
         // Read sees the pre-write value on a same-cycle collision
         r_rd_char <= r_shadow[iRD_ADDR];
         if (w_accept) begin
            r_ac   <= w_ac_nxt;
            r_id   <= w_id_nxt;
            r_disp <= w_disp_nxt;
            if (w_clear)
               for (int i = 0; i < 32; i++) r_shadow[i] <= 8'h20;
            else if (w_wr_en)
               r_shadow[w_wr_idx] <= w_data;
         end
      end
   end

   assign oRD_CHAR     = r_rd_char;
   assign oCURSOR_ADDR = r_ac;
   assign oDISP_ON     = r_disp;
   assign oBUSY        = (r_state == ST_BUSY);
   assign oWR_STB      = r_wr_stb;
   assign oCMD_ERR     = r_cmd_err;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Self-checking bench for lcd_bus_receiver with short busy times.
module tb_lcd_bus_receiver;
   localparam int CMD = 8;
   localparam int CLR = 20;

   logic       iCLK = 1'b0, iRST_N = 1'b0;
   logic [7:0] LCD_DATA = '0;
   logic       LCD_RS = 1'b0, LCD_RW = 1'b0, LCD_EN = 1'b0;
   logic [4:0] iRD_ADDR = '0;
   logic [7:0] oRD_CHAR;
   logic [6:0] oCURSOR_ADDR;
   logic       oDISP_ON, oBUSY, oWR_STB, oCMD_ERR;

   lcd_bus_receiver #(.CMD_BUSY_CYC(CMD), .CLR_BUSY_CYC(CLR)) dut (
      .iCLK(iCLK), .iRST_N(iRST_N), .LCD_DATA(LCD_DATA), .LCD_RS(LCD_RS),
      .LCD_RW(LCD_RW), .LCD_EN(LCD_EN), .iRD_ADDR(iRD_ADDR), .oRD_CHAR(oRD_CHAR),
      .oCURSOR_ADDR(oCURSOR_ADDR), .oDISP_ON(oDISP_ON), .oBUSY(oBUSY),
      .oWR_STB(oWR_STB), .oCMD_ERR(oCMD_ERR));

   always #5 iCLK = ~iCLK;

   int checks = 0, failures = 0;

   // Reference model
   logic [7:0] m_sh [32];
   int         m_ac;
   bit         m_id, m_disp;
   int         exp_wr, exp_err;

   // Observed pulse counts and busy-run length
   int obs_wr = 0, obs_err = 0, busy_run = 0, last_busy_len = 0;
   always @(negedge iCLK) begin
      if (!iRST_N) begin
         obs_wr = 0; obs_err = 0; busy_run = 0;
      end else begin
         if (oWR_STB) obs_wr++;
         if (oCMD_ERR) obs_err++;
         if (oBUSY) busy_run++;
         else if (busy_run > 0) begin last_busy_len = busy_run; busy_run = 0; end
      end
   end

   // DDRAM visible addresses as one 80-long ring: positions 0-39 are
   // 0x00-0x27, positions 40-79 are 0x40-0x67.
   function automatic int step(int a, bit up);
      int p;
      if (a <= 'h27) p = a;
      else if (a >= 'h40 && a <= 'h67) p = a - 'h40 + 40;
      else return up ? (a + 1) % 128 : (a + 127) % 128;
      p = up ? (p + 1) % 80 : (p + 79) % 80;
      return (p < 40) ? p : p - 40 + 'h40;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_sh[i] = 8'h20;
      m_ac = 0; m_id = 1; m_disp = 0; exp_wr = 0; exp_err = 0;
   endtask

   task automatic model_apply(bit rs, logic [7:0] d, output int blen);
      blen = CMD;
      if (rs) begin
         if (m_ac < 16) m_sh[m_ac] = d;
         else if (m_ac >= 'h40 && m_ac < 'h50) m_sh[16 + m_ac - 'h40] = d;
         exp_wr++;
         m_ac = step(m_ac, m_id);
      end
      else if (d[7]) m_ac = d[6:0];
      else if (d[6] || d[5]) ;
      else if (d[4]) begin if (!d[3]) m_ac = step(m_ac, d[2]); end
      else if (d[3]) m_disp = d[2];
      else if (d[2]) m_id = d[1];
      else if (d[1]) begin m_ac = 0; blen = CLR; end
      else if (d[0]) begin
         for (int i = 0; i < 32; i++) m_sh[i] = 8'h20;
         m_ac = 0; m_id = 1; blen = CLR;
      end
   endtask

   task automatic drive_strobe(bit rs, bit rw, logic [7:0] d);
      @(negedge iCLK);
      LCD_DATA = d; LCD_RS = rs; LCD_RW = rw; LCD_EN = 1'b1;
      repeat (3) @(negedge iCLK);
      LCD_EN = 1'b0;
   endtask

   task automatic wait_idle(string nm);
      int n = 0;
      while (oBUSY && n < 200) begin @(negedge iCLK); n++; end
      @(negedge iCLK);
      checks++;
      if (n >= 200) begin failures++; $display("FAIL %s busy timeout", nm); end
   endtask

   task automatic check_state(string nm, int blen);
      checks++;
      if (last_busy_len !== blen) begin failures++;
         $display("FAIL %s busy_len got=%0d exp=%0d", nm, last_busy_len, blen); end
      checks++;
      if (oCURSOR_ADDR !== 7'(m_ac)) begin failures++;
         $display("FAIL %s ac got=%h exp=%h", nm, oCURSOR_ADDR, m_ac); end
      checks++;
      if (oDISP_ON !== m_disp) begin failures++;
         $display("FAIL %s disp got=%b exp=%b", nm, oDISP_ON, m_disp); end
      checks++;
      if (obs_wr !== exp_wr || obs_err !== exp_err) begin failures++;
         $display("FAIL %s pulses wr=%0d/%0d err=%0d/%0d", nm, obs_wr, exp_wr, obs_err, exp_err); end
   endtask

   task automatic lcd_op(bit rs, bit rw, logic [7:0] d, string nm);
      int blen;
      last_busy_len = 0;
      drive_strobe(rs, rw, d);
      repeat (3) @(negedge iCLK);
      if (rw) begin blen = 0; exp_err++; end
      else model_apply(rs, d, blen);
      wait_idle(nm);
      check_state(nm, blen);
   endtask

   task automatic sweep(string nm);
      for (int i = 0; i < 32; i++) begin
         @(negedge iCLK); iRD_ADDR = 5'(i);
         @(negedge iCLK);
         checks++;
         if (oRD_CHAR !== m_sh[i]) begin failures++;
            $display("FAIL %s shadow[%0d] got=%h exp=%h", nm, i, oRD_CHAR, m_sh[i]); end
      end
   endtask

   task automatic test_reset();
      model_reset();
      iRST_N = 1'b0;
      repeat (3) @(negedge iCLK);
      checks++;
      if ({oRD_CHAR, oCURSOR_ADDR, oDISP_ON, oBUSY, oWR_STB, oCMD_ERR} !== '0) begin
         failures++; $display("FAIL reset_outputs got=%h/%h/%b/%b/%b/%b exp=0",
            oRD_CHAR, oCURSOR_ADDR, oDISP_ON, oBUSY, oWR_STB, oCMD_ERR); end
      iRST_N = 1'b1;
      sweep("reset");
      check_state("reset", 0);
   endtask

   task automatic test_init();
      lcd_op(0, 0, 8'h38, "init_38");
      lcd_op(0, 0, 8'h0C, "init_0C");
      lcd_op(0, 0, 8'h01, "init_01");
      lcd_op(0, 0, 8'h06, "init_06");
      lcd_op(0, 0, 8'h80, "init_80");
   endtask

   task automatic test_line_wrap();
      lcd_op(0, 0, 8'h8F, "wr_8F");
      lcd_op(1, 0, 8'h41, "wr_d41");
      lcd_op(0, 0, 8'hC0, "wr_C0");
      lcd_op(1, 0, 8'h30, "wr_d30");
      sweep("lines");
      lcd_op(0, 0, 8'hE7, "wr_E7");
      lcd_op(1, 0, 8'h42, "wr_offscreen");
      lcd_op(0, 0, 8'h04, "wr_id0");
      lcd_op(1, 0, 8'h43, "wr_dec");
      sweep("offscreen");
   endtask

   task automatic test_busy_reject();
      int blen;
      last_busy_len = 0;
      drive_strobe(1, 0, 8'h5A);
      model_apply(1, 8'h5A, blen);
      repeat (2) @(negedge iCLK);
      drive_strobe(1, 0, 8'h55);
      exp_err++;
      repeat (3) @(negedge iCLK);
      wait_idle("busy_reject");
      check_state("busy_reject", blen);
      sweep("busy_reject");
   endtask

   task automatic test_random();
      for (int n = 0; n < 60; n++) begin
         int r = $urandom_range(0, 9);
         logic [7:0] d = 8'($urandom);
         if (r < 5) lcd_op(1, 0, d, "rnd_data");
         else if (r == 5) lcd_op($urandom_range(0, 1), 1, d, "rnd_read");
         else begin
            int k = $urandom_range(0, 8);
            logic [8:0] one = 9'd1 << k;
            if (k == 8) d = 8'h00;
            else d = one[7:0] | (d & (one[7:0] - 8'd1));
            lcd_op(0, 0, d, "rnd_cmd");
         end
      end
      sweep("random");
   endtask

   task automatic test_reset_mid_busy();
      lcd_op(0, 0, 8'h8F, "rst_8F");
      drive_strobe(1, 0, 8'h41);
      repeat (4) @(negedge iCLK);
      checks++;
      if (oBUSY !== 1'b1) begin failures++; $display("FAIL rst_pre_busy got=%b exp=1", oBUSY); end
      iRST_N = 1'b0;
      #1;
      checks++;
      if (oBUSY !== 1'b0 || oCURSOR_ADDR !== 7'd0) begin failures++;
         $display("FAIL rst_mid_busy busy=%b ac=%h exp=0/0", oBUSY, oCURSOR_ADDR); end
      model_reset();
      @(negedge iCLK); iRST_N = 1'b1;
      sweep("rst_mid_busy");
   endtask

   initial begin
      test_reset();
      test_init();
      test_line_wrap();
      test_busy_reject();
      test_random();
      test_reset_mid_busy();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
